// File: rtl/nebula_pkg.sv
// Shared NoC definitions: flit header layout, widths, VC and message codes,
// plus the injection arbiter state type.
package nebula_pkg;

    localparam int FLIT_PAYLOAD_W = 32;

    // Virtual channel assignment
    localparam int VC_REQ   = 0;
    localparam int VC_DATA0 = 1;
    localparam int VC_DATA1 = 2;
    localparam int VC_RSP   = 3;

    // Message type codes carried in the header
    localparam logic [2:0] NOC_MSG_RD_REQ  = 3'd0;
    localparam logic [2:0] NOC_MSG_WR_REQ  = 3'd1;
    localparam logic [2:0] NOC_MSG_WR_DATA = 3'd2;
    localparam logic [2:0] NOC_MSG_RD_RSP  = 3'd3;
    localparam logic [2:0] NOC_MSG_WR_RSP  = 3'd4;

    // Header occupies the flit MSBs; head and tail lead so they sit at fixed bits
    typedef struct packed {
        logic       head;
        logic       tail;
        logic [2:0] vclass;
        logic [2:0] msg;
        logic [7:0] dest;
    } flit_hdr_t;

    localparam int FLIT_HDR_W = $bits(flit_hdr_t);
    localparam int NOC_FLIT_W = FLIT_HDR_W + FLIT_PAYLOAD_W;
    localparam int VCLASS_W   = 3;

    // Header field positions counted down from the flit MSB
    localparam int HDR_HEAD_OFS = 1;
    localparam int HDR_TAIL_OFS = 2;
    localparam int HDR_VC_OFS   = 3;

    // Injection arbiter states
    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/nebula_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module nebula_rr_pick #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] scan;

    // Scan offsets from farthest to nearest so the nearest request is kept last
    always_comb begin
        idx  = '0;
        scan = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[scan]) begin
                idx = scan;
            end
        end
        grant = (|req) ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/nebula_niu_tx_arb.sv
// Wormhole round-robin arbiter sharing the NoC injection link between NIU
// flit sources, with per-VC credit gating toward the router input buffer.
// Handshake: a flit moves when tx_valid & tx_ready; tx_valid never depends on
// tx_ready, and the presented flit is held stable until it is accepted.
module nebula_niu_tx_arb
    import nebula_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int NUM_VC  = 4,
    parameter int CREDITS = 4,
    parameter int FLIT_W  = NOC_FLIT_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*FLIT_W-1:0]             req_flit,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic                                  tx_valid,
    output logic [FLIT_W-1:0]                     tx_flit,
    input  logic                                  tx_ready,
    input  logic                                  credit_valid,
    input  logic [7:0]                            credit_vc,
    output logic [NUM_VC*$clog2(CREDITS+1)-1:0]   credit_cnt,
    output logic                                  busy,
    output logic                                  err,
    output arb_state_e                            state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS + 1);

    logic [IW-1:0]         rr_ptr, lock_id, hold_id, pick_idx, sel_id;
    logic                  hold_q;
    logic [CW-1:0]         credit_q [NUM_VC];
    logic [NUM_REQ-1:0]    src_head, src_tail, cand, pick_grant;
    logic [VCLASS_W-1:0]   src_vc [NUM_REQ];
    logic                  sel_valid, sel_head, sel_tail, vc_ok, has_credit, accept;
    logic [VCLASS_W-1:0]   sel_vc;
    logic [NUM_VC-1:0]     inc_vec, dec_vec, full_vec;
    logic                  bad_cvc, overflow, lock_head_err;

    // Decode per-source header fields; only head flits compete while idle
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            src_head[i] = req_flit[i*FLIT_W + FLIT_W - HDR_HEAD_OFS];
            src_tail[i] = req_flit[i*FLIT_W + FLIT_W - HDR_TAIL_OFS];
            src_vc[i]   = req_flit[i*FLIT_W + FLIT_W - HDR_VC_OFS -: VCLASS_W];
            cand[i]     = req_valid[i] & src_head[i];
        end
    end

    nebula_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Choose the source on the link: locked owner, held pick, or fresh pick
    always_comb begin
        if (state == ARB_LOCKED) begin
            sel_id    = lock_id;
            sel_valid = req_valid[lock_id];
        end else if (hold_q) begin
            sel_id    = hold_id;
            sel_valid = cand[hold_id];
        end else begin
            sel_id    = pick_idx;
            sel_valid = |pick_grant;
        end
        sel_head = src_head[sel_id];
        sel_tail = src_tail[sel_id];
        sel_vc   = src_vc[sel_id];
    end

    // Credit lookup for the selected flit's VC; out-of-range VCs are never ok
    always_comb begin
        vc_ok      = 1'b0;
        has_credit = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (int'(sel_vc) == v) begin
                vc_ok      = 1'b1;
                has_credit = (credit_q[v] != '0);
            end
        end
    end

    assign tx_flit  = req_flit[int'(sel_id)*FLIT_W +: FLIT_W];
    assign tx_valid = sel_valid & vc_ok & has_credit;
    assign accept   = tx_valid & tx_ready;
    assign busy     = (state == ARB_LOCKED);

    // Only the selected source sees ready, and only on a handshake
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel_id] = 1'b1;
        end
    end

    // Per-VC consume/return strobes and the packed credit view
    always_comb begin
        inc_vec    = '0;
        dec_vec    = '0;
        full_vec   = '0;
        credit_cnt = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            inc_vec[v]             = credit_valid & (int'(credit_vc) == v);
            dec_vec[v]             = accept & (int'(sel_vc) == v);
            full_vec[v]            = (credit_q[v] == CW'(CREDITS));
            credit_cnt[v*CW +: CW] = credit_q[v];
        end
    end

    assign bad_cvc       = credit_valid & (int'(credit_vc) >= NUM_VC);
    assign overflow      = |(inc_vec & ~dec_vec & full_vec);
    assign lock_head_err = (state == ARB_LOCKED) & sel_valid & sel_head;

    // Arbitration FSM: pointer advance, packet lock and pick hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
            hold_q  <= 1'b0;
            hold_id <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    hold_q  <= tx_valid & ~tx_ready;
                    hold_id <= sel_id;
                    if (accept) begin
                        rr_ptr <= (int'(sel_id) == NUM_REQ - 1) ? '0 : sel_id + 1'b1;
                        if (!sel_tail) begin
                            lock_id <= sel_id;
                            state   <= ARB_LOCKED;
                        end
                    end
                end
                ARB_LOCKED: begin
                    hold_q <= 1'b0;
                    if (accept && sel_tail) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Credit counters: simultaneous consume and return cancel; saturate at CREDITS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= CW'(CREDITS);
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (inc_vec[v] && !dec_vec[v] && !full_vec[v]) begin
                    credit_q[v] <= credit_q[v] + 1'b1;
                end else if (dec_vec[v] && !inc_vec[v]) begin
                    credit_q[v] <= credit_q[v] - 1'b1;
                end
            end
        end
    end

    // Sticky error: credit overflow, bad credit VC, bad flit VC, head inside a packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (overflow || bad_cvc || (sel_valid && !vc_ok) || lock_head_err) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nebula_niu_tx_arb.sv
// Directed bench for the NIU injection arbiter with a flit scoreboard.
module tb_nebula_niu_tx_arb;
    import nebula_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int NUM_VC  = 4;
    localparam int CREDITS = 4;
    localparam int FW      = NOC_FLIT_W;
    localparam int CW      = $clog2(CREDITS + 1);
    localparam int W       = NUM_REQ + FW;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b1;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ*FW-1:0]       req_flit = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        tx_valid;
    logic [FW-1:0]               tx_flit;
    logic                        tx_ready = 1'b1;
    logic                        credit_valid = 1'b0;
    logic [7:0]                  credit_vc = '0;
    logic [NUM_VC*CW-1:0]        credit_cnt;
    logic                        busy;
    logic                        err;
    arb_state_e                  state;

    logic [FW-1:0]               src_q0[$], src_q1[$], src_q2[$];
    logic [W-1:0]                exp_q[$];
    logic [FW-1:0]               f [8];
    logic [NUM_REQ-1:0]          rdy_s = '0;
    logic [NUM_VC*CW-1:0]        full_cnt;
    int                          n_asrt = 0;
    int                          n_fail = 0;

    nebula_niu_tx_arb #(
        .NUM_REQ (NUM_REQ),
        .NUM_VC  (NUM_VC),
        .CREDITS (CREDITS),
        .FLIT_W  (FW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_flit     (req_flit),
        .req_ready    (req_ready),
        .tx_valid     (tx_valid),
        .tx_flit      (tx_flit),
        .tx_ready     (tx_ready),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .credit_cnt   (credit_cnt),
        .busy         (busy),
        .err          (err),
        .state        (state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic head, input logic tail, input int vc);
        flit_hdr_t h;
        h.head   = head;
        h.tail   = tail;
        h.vclass = 3'(vc);
        h.msg    = NOC_MSG_WR_DATA;
        h.dest   = 8'($urandom_range(0, 255));
        return {h, FLIT_PAYLOAD_W'($urandom())};
    endfunction

    function automatic logic [CW-1:0] cnt(input int v);
        return credit_cnt[v*CW +: CW];
    endfunction

    task automatic sb_push(input int src, input logic [FW-1:0] fl);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[src] = 1'b1;
        exp_q.push_back({oh, fl});
    endtask

    // Drive each source's queue head onto its lane
    task automatic present();
        req_valid[0] = (src_q0.size() > 0);
        req_valid[1] = (src_q1.size() > 0);
        req_valid[2] = (src_q2.size() > 0);
        req_flit[0*FW +: FW] = (src_q0.size() > 0) ? src_q0[0] : '0;
        req_flit[1*FW +: FW] = (src_q1.size() > 0) ? src_q1[0] : '0;
        req_flit[2*FW +: FW] = (src_q2.size() > 0) ? src_q2[0] : '0;
    endtask

    // One cycle: check the handshake at negedge, then advance sources after posedge
    task automatic tick();
        logic [W-1:0] obs, exp;
        @(negedge clk);
        rdy_s = req_ready;
        if (tx_valid && tx_ready) begin
            obs = {req_ready, tx_flit};
            exp = 'x;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            chk("sb_flit", 64'(obs), 64'(exp));
        end else begin
            chk("rdy_idle", 64'(req_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        if (rdy_s[0] && src_q0.size() > 0) void'(src_q0.pop_front());
        if (rdy_s[1] && src_q1.size() > 0) void'(src_q1.pop_front());
        if (rdy_s[2] && src_q2.size() > 0) void'(src_q2.pop_front());
        present();
    endtask

    task automatic clear_srcs();
        src_q0.delete();
        src_q1.delete();
        src_q2.delete();
        rdy_s = '0;
        present();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_ready = 1'b1;
        credit_valid = 1'b0;
        clear_srcs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int v = 0; v < NUM_VC; v++) full_cnt[v*CW +: CW] = CW'(CREDITS);

        // 1: reset values, then a credit return at full count
        present();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cnt", 64'(credit_cnt), 64'(full_cnt));
        chk("rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_state", 64'(state), 64'(ARB_IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        credit_valid = 1'b1;
        credit_vc = 8'(VC_DATA1);
        tick();
        credit_valid = 1'b0;
        #1;
        chk("ovf_err", 64'(err), 64'(1));
        chk("ovf_cnt", 64'(credit_cnt), 64'(full_cnt));

        // 2: two sources contend with single-flit heads on VC_REQ
        do_reset();
        chk("t2_err_clr", 64'(err), 64'(0));
        for (int k = 0; k < 3; k++) begin
            f[k] = mk(1'b1, 1'b1, VC_REQ);
            f[k+3] = mk(1'b1, 1'b1, VC_REQ);
            src_q0.push_back(f[k]);
            src_q1.push_back(f[k+3]);
        end
        sb_push(0, f[0]);
        sb_push(1, f[3]);
        sb_push(0, f[1]);
        sb_push(1, f[4]);
        present();
        repeat (4) tick();
        #1;
        chk("t2_cnt_req", 64'(cnt(VC_REQ)), 64'(0));
        chk("t2_cnt_d0", 64'(cnt(VC_DATA0)), 64'(CREDITS));
        chk("t2_stall", 64'(tx_valid), 64'(0));
        tick();
        chk("t2_stall2", 64'(tx_valid), 64'(0));

        // 3: src1 packet locks the link while src0 holds a head
        do_reset();
        f[0] = mk(1'b1, 1'b1, VC_REQ);
        f[1] = mk(1'b1, 1'b1, VC_REQ);
        f[2] = mk(1'b1, 1'b0, VC_REQ);
        f[3] = mk(1'b0, 1'b0, VC_DATA0);
        f[4] = mk(1'b0, 1'b1, VC_DATA0);
        src_q0.push_back(f[0]);
        src_q0.push_back(f[1]);
        for (int k = 2; k < 5; k++) src_q1.push_back(f[k]);
        sb_push(0, f[0]);
        sb_push(1, f[2]);
        sb_push(1, f[3]);
        sb_push(1, f[4]);
        sb_push(0, f[1]);
        present();
        tick();
        tick();
        #1 chk("t3_busy_head", 64'(busy), 64'(1));
        tick();
        #1 chk("t3_busy_body", 64'(busy), 64'(1));
        tick();
        #1;
        chk("t3_busy_tail", 64'(busy), 64'(0));
        chk("t3_src0_next", 64'(req_ready), 64'(3'b001));
        tick();
        #1;
        chk("t3_cnt_req", 64'(cnt(VC_REQ)), 64'(1));
        chk("t3_cnt_d0", 64'(cnt(VC_DATA0)), 64'(2));
        chk("t3_err", 64'(err), 64'(0));

        // 4: VC_DATA0 runs dry, one returned credit releases one flit
        for (int k = 0; k < 3; k++) begin
            f[k] = mk(1'b1, 1'b1, VC_DATA0);
            src_q2.push_back(f[k]);
            sb_push(2, f[k]);
        end
        present();
        tick();
        tick();
        #1;
        chk("t4_cnt_zero", 64'(cnt(VC_DATA0)), 64'(0));
        chk("t4_stall", 64'(tx_valid), 64'(0));
        tick();
        chk("t4_stall2", 64'(tx_valid), 64'(0));
        credit_valid = 1'b1;
        credit_vc = 8'(VC_DATA0);
        tick();
        credit_valid = 1'b0;
        #1;
        chk("t4_cnt_one", 64'(cnt(VC_DATA0)), 64'(1));
        chk("t4_release", 64'(tx_valid), 64'(1));
        chk("t4_flit", 64'(tx_flit), 64'(f[2]));
        tick();
        #1;
        chk("t4_cnt_back", 64'(cnt(VC_DATA0)), 64'(0));

        // 5: consume and return together, then backpressure
        credit_valid = 1'b1;
        credit_vc = 8'(VC_REQ);
        tick();
        credit_valid = 1'b0;
        #1 chk("t5_cnt_two", 64'(cnt(VC_REQ)), 64'(2));
        f[5] = mk(1'b1, 1'b1, VC_REQ);
        src_q0.push_back(f[5]);
        sb_push(0, f[5]);
        present();
        credit_valid = 1'b1;
        credit_vc = 8'(VC_REQ);
        tick();
        credit_valid = 1'b0;
        #1;
        chk("t5_cnt_same", 64'(cnt(VC_REQ)), 64'(2));
        chk("t5_err", 64'(err), 64'(0));
        tx_ready = 1'b0;
        f[6] = mk(1'b1, 1'b1, VC_REQ);
        src_q0.push_back(f[6]);
        sb_push(0, f[6]);
        present();
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("t5_bp_valid", 64'(tx_valid), 64'(1));
            chk("t5_bp_flit", 64'(tx_flit), 64'(f[6]));
            chk("t5_bp_ready", 64'(req_ready), 64'(0));
        end
        tx_ready = 1'b1;
        tick();
        #1 chk("t5_cnt_after", 64'(cnt(VC_REQ)), 64'(1));

        // 6: reset in the middle of a 4-flit packet
        f[0] = mk(1'b1, 1'b1, VC_REQ);
        f[1] = mk(1'b1, 1'b0, VC_REQ);
        f[2] = mk(1'b0, 1'b0, VC_DATA0);
        f[3] = mk(1'b0, 1'b0, VC_DATA0);
        f[4] = mk(1'b0, 1'b1, VC_DATA0);
        src_q0.push_back(f[0]);
        for (int k = 1; k < 5; k++) src_q1.push_back(f[k]);
        sb_push(1, f[1]);
        present();
        credit_valid = 1'b1;
        credit_vc = 8'(VC_DATA0);
        tick();
        credit_valid = 1'b0;
        #1 chk("t6_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_cnt", 64'(credit_cnt), 64'(full_cnt));
        chk("t6_rst_state", 64'(state), 64'(ARB_IDLE));
        clear_srcs();
        #1 chk("t6_rst_txv", 64'(tx_valid), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        f[5] = mk(1'b1, 1'b1, VC_REQ);
        f[6] = mk(1'b1, 1'b1, VC_DATA1);
        src_q1.push_back(f[5]);
        src_q2.push_back(f[6]);
        sb_push(1, f[5]);
        sb_push(2, f[6]);
        present();
        tick();
        tick();
        #1 chk("t6_err", 64'(err), 64'(0));

        // 7a: flit with an out-of-range VC is never sent
        do_reset();
        f[0] = mk(1'b1, 1'b1, 5);
        src_q0.push_back(f[0]);
        present();
        #1;
        chk("t7_badvc_txv", 64'(tx_valid), 64'(0));
        chk("t7_badvc_pre", 64'(err), 64'(0));
        tick();
        #1;
        chk("t7_badvc_err", 64'(err), 64'(1));
        chk("t7_badvc_txv2", 64'(tx_valid), 64'(0));

        // 7b: credit return on an out-of-range VC
        do_reset();
        credit_valid = 1'b1;
        credit_vc = 8'd6;
        tick();
        credit_valid = 1'b0;
        #1;
        chk("t7_cvc_err", 64'(err), 64'(1));
        chk("t7_cvc_cnt", 64'(credit_cnt), 64'(full_cnt));

        // 7c: head flit inside a locked packet is forwarded and flagged
        do_reset();
        f[0] = mk(1'b1, 1'b0, VC_REQ);
        f[1] = mk(1'b1, 1'b1, VC_DATA0);
        src_q0.push_back(f[0]);
        src_q0.push_back(f[1]);
        sb_push(0, f[0]);
        sb_push(0, f[1]);
        present();
        tick();
        #1;
        chk("t7_lock_pre", 64'(err), 64'(0));
        chk("t7_lock_busy", 64'(busy), 64'(1));
        tick();
        #1;
        chk("t7_lock_err", 64'(err), 64'(1));
        chk("t7_lock_idle", 64'(busy), 64'(0));

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
